// File: rtl/codec_seq_init_unit_if.sv
// Strobe/response bus between the init sequencer and the I2C register-access engine.
interface codec_seq_init_unit_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
);
    logic              codec_rd_en;
    logic              codec_wr_en;
    logic [ADDR_W-1:0] codec_reg_addr;
    logic [DATA_W-1:0] codec_data_out;
    logic [DATA_W-1:0] codec_data_in;
    logic              codec_data_in_valid;
    logic              codec_wr_done;

    modport master (
        output codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out,
        input  codec_data_in, codec_data_in_valid, codec_wr_done
    );

    modport slave (
        input  codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out,
        output codec_data_in, codec_data_in_valid, codec_wr_done
    );
endinterface

// File: rtl/codec_seq_init_unit.sv
// CODEC init sequencer: probes an ID register, then writes (and optionally verifies)
// a parameter table with per-transaction timeout and bounded retries.
module codec_seq_init_unit #(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned NUM_ENTRIES    = 4,
    parameter logic [NUM_ENTRIES*ADDR_W-1:0] INIT_ADDR = {9'h009, 9'h006, 9'h005, 9'h004},
    parameter logic [NUM_ENTRIES*DATA_W-1:0] INIT_DATA = {8'h01, 8'h30, 8'h00, 8'h12},
    parameter logic [ADDR_W-1:0] PROBE_ADDR  = '0,
    parameter logic [DATA_W-1:0] PROBE_VALUE = 8'h97,
    parameter bit          VERIFY_EN      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    codec_seq_init_unit_if.master codec,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] error_code,
    output logic [3:0] error_index
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    LAST_IDX = 4'(NUM_ENTRIES - 1);
    localparam logic [2:0]    R_MAX    = 3'(MAX_RETRIES);

    typedef enum logic [3:0] {
        S_PROBE_RD, S_PROBE_WAIT, S_WR, S_WR_WAIT,
        S_VFY_RD, S_VFY_WAIT, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t state, state_n;
    logic [3:0]        idx, idx_n;
    logic [2:0]        retry, retry_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic              fail;
    logic [1:0]        fail_code;
    logic [ADDR_W-1:0] ent_addr;
    logic [DATA_W-1:0] ent_data;

    logic              rd_q, wr_q, rd_n, wr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] dout_q, dout_n;
    logic              busy_n, done_n, err_n;
    logic [1:0]        code_n;
    logic [3:0]        eidx_n;

    logic rsp_win, to_hit;
    // tcnt==0 is the strobe cycle itself; responses there are not sampled
    assign rsp_win = (tcnt != '0);
    assign to_hit  = (tcnt == T_LAST);

    always_comb begin
        ent_addr = '0;
        ent_data = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (idx == 4'(i)) begin
                ent_addr = INIT_ADDR[i*ADDR_W +: ADDR_W];
                ent_data = INIT_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_PROBE_RD;
            idx         <= '0;
            retry       <= '0;
            tcnt        <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            busy        <= 1'b1;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
            error_code  <= '0;
            error_index <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            retry       <= retry_n;
            tcnt        <= tcnt_n;
            rd_q        <= rd_n;
            wr_q        <= wr_n;
            addr_q      <= addr_n;
            dout_q      <= dout_n;
            busy        <= busy_n;
            init_done   <= done_n;
            init_error  <= err_n;
            error_code  <= code_n;
            error_index <= eidx_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        retry_n   = retry;
        tcnt_n    = tcnt;
        fail      = 1'b0;
        fail_code = 2'd0;
        unique case (state)
            S_PROBE_RD: begin
                state_n = S_PROBE_WAIT;
                tcnt_n  = '0;
            end
            S_PROBE_WAIT: begin
                if (rsp_win && codec.codec_data_in_valid) begin
                    if (codec.codec_data_in == PROBE_VALUE) begin
                        state_n = S_WR;
                        idx_n   = '0;
                        retry_n = '0;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'd1;
                    end
                end else if (to_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_WR: begin
                state_n = S_WR_WAIT;
                tcnt_n  = '0;
            end
            S_WR_WAIT: begin
                if (rsp_win && codec.codec_wr_done) begin
                    state_n = VERIFY_EN ? S_VFY_RD : S_NEXT;
                end else if (to_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_VFY_RD: begin
                state_n = S_VFY_WAIT;
                tcnt_n  = '0;
            end
            S_VFY_WAIT: begin
                if (rsp_win && codec.codec_data_in_valid) begin
                    if (codec.codec_data_in == ent_data) begin
                        state_n = S_NEXT;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'd3;
                    end
                end else if (to_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_NEXT: begin
                retry_n = '0;
                if (idx == LAST_IDX) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 4'd1;
                    state_n = S_WR;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_n = S_PROBE_RD;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            default: state_n = S_PROBE_RD;
        endcase

        // Probe failures re-issue the probe; write and verify failures both re-issue the write.
        if (fail) begin
            if (retry < R_MAX) begin
                retry_n = retry + 3'd1;
                state_n = (state == S_PROBE_WAIT) ? S_PROBE_RD : S_WR;
            end else begin
                state_n = S_ERROR;
            end
        end
    end

    always_comb begin
        rd_n   = 1'b0;
        wr_n   = 1'b0;
        addr_n = addr_q;
        dout_n = dout_q;
        busy_n = busy;
        done_n = init_done;
        err_n  = init_error;
        code_n = error_code;
        eidx_n = error_index;
        case (state)
            S_PROBE_RD: begin
                rd_n   = 1'b1;
                addr_n = PROBE_ADDR;
            end
            S_WR: begin
                wr_n   = 1'b1;
                addr_n = ent_addr;
                dout_n = ent_data;
            end
            S_VFY_RD: begin
                rd_n   = 1'b1;
                addr_n = ent_addr;
            end
            default: ;
        endcase
        if (state_n == S_DONE && state != S_DONE) begin
            done_n = 1'b1;
            busy_n = 1'b0;
            addr_n = '0;
            dout_n = '0;
        end
        if (state_n == S_ERROR && state != S_ERROR) begin
            err_n  = 1'b1;
            busy_n = 1'b0;
            code_n = fail_code;
            eidx_n = idx;
        end
        if ((state == S_DONE || state == S_ERROR) && state_n == S_PROBE_RD) begin
            done_n = 1'b0;
            err_n  = 1'b0;
            code_n = '0;
            eidx_n = '0;
            busy_n = 1'b1;
        end
    end

    assign codec.codec_rd_en    = rd_q;
    assign codec.codec_wr_en    = wr_q;
    assign codec.codec_reg_addr = addr_q;
    assign codec.codec_data_out = dout_q;
endmodule

// File: tb/tb_codec_seq_init_unit.sv
// Randomised responder-driven bench for two sequencer instances (verify on / verify off),
// checked against a transaction-level model of the expected init sequence.
module tb_codec_seq_init_unit;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int NE   = 4;
    localparam int MAXR = 2;
    localparam int TO   = 16;
    localparam logic [8:0] PADDR = 9'h000;
    localparam logic [7:0] PVAL  = 8'h97;

    typedef struct {
        bit         is_wr;
        logic [8:0] a;
        logic [7:0] dat;
        int         cyc;
        bit         gap18;
    } tx_t;

    logic [8:0] taddr_a [NE] = '{9'h004, 9'h005, 9'h006, 9'h009};
    logic [7:0] tdata_a [NE] = '{8'h12, 8'h00, 8'h30, 8'h01};

    logic clk = 1'b0;
    logic reset, restart;
    int   cyc = 0;
    int   checks = 0, errs = 0, run = 0;

    logic [1:0]         rd, wr, dval, wdone, busy, done, err;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] dout, din;
    logic [1:0][1:0]    code;
    logic [1:0][3:0]    eidx;

    int pbad, fe, kind, nbad;
    int pcnt [2];
    int bcnt [2];
    logic [7:0] mem [2][NE];
    tx_t mlog0[$], mlog1[$], exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    codec_seq_init_unit_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    codec_seq_init_unit_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    assign ifa.codec_data_in = din[0];  assign ifa.codec_data_in_valid = dval[0];  assign ifa.codec_wr_done = wdone[0];
    assign ifb.codec_data_in = din[1];  assign ifb.codec_data_in_valid = dval[1];  assign ifb.codec_wr_done = wdone[1];
    assign rd[0] = ifa.codec_rd_en;  assign wr[0] = ifa.codec_wr_en;  assign addr[0] = ifa.codec_reg_addr;  assign dout[0] = ifa.codec_data_out;
    assign rd[1] = ifb.codec_rd_en;  assign wr[1] = ifb.codec_wr_en;  assign addr[1] = ifb.codec_reg_addr;  assign dout[1] = ifb.codec_data_out;

    codec_seq_init_unit #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_ENTRIES(NE),
        .INIT_ADDR({9'h009, 9'h006, 9'h005, 9'h004}), .INIT_DATA({8'h01, 8'h30, 8'h00, 8'h12}),
        .PROBE_ADDR(PADDR), .PROBE_VALUE(PVAL), .VERIFY_EN(1'b1),
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)
    ) dut_a (
        .clk(clk), .reset(reset), .restart(restart), .codec(ifa),
        .busy(busy[0]), .init_done(done[0]), .init_error(err[0]),
        .error_code(code[0]), .error_index(eidx[0])
    );

    codec_seq_init_unit #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_ENTRIES(NE),
        .INIT_ADDR({9'h009, 9'h006, 9'h005, 9'h004}), .INIT_DATA({8'h01, 8'h30, 8'h00, 8'h12}),
        .PROBE_ADDR(PADDR), .PROBE_VALUE(PVAL), .VERIFY_EN(1'b0),
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)
    ) dut_b (
        .clk(clk), .reset(reset), .restart(restart), .codec(ifb),
        .busy(busy[1]), .init_done(done[1]), .init_error(err[1]),
        .error_code(code[1]), .error_index(eidx[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (run %0d, cycle %0d)", tag, got, exp, run, cyc);
        end
    endtask

    function automatic int ent_of(input logic [8:0] a);
        for (int i = 0; i < NE; i++) if (taddr_a[i] == a) return i;
        return -1;
    endfunction

    // Register-engine stand-in: random latency, occasional stray responses in the strobe
    // cycle and on the wrong response line, scripted faults from the scenario variables.
    task automatic responder(input int d);
        tx_t t;
        int e, lat;
        bit spur, drop;
        logic [7:0] rv;
        forever begin
            @(negedge clk);
            if (!reset && (rd[d] || wr[d])) begin
                t.is_wr = wr[d]; t.a = addr[d]; t.dat = dout[d]; t.cyc = cyc; t.gap18 = 1'b0;
                if (d == 0) mlog0.push_back(t); else mlog1.push_back(t);
                e = ent_of(addr[d]); drop = 1'b0; rv = 8'h00;
                if (t.is_wr) begin
                    if (e >= 0) mem[d][e] = dout[d];
                    if (kind == 2 && e == fe && bcnt[d] < nbad) begin drop = 1'b1; bcnt[d]++; end
                end else if (t.a == PADDR) begin
                    rv = (pcnt[d] < pbad) ? 8'h55 : PVAL;
                    pcnt[d]++;
                end else begin
                    rv = (e >= 0) ? mem[d][e] : 8'hEE;
                    if (kind == 1 && e == fe && bcnt[d] < nbad) begin rv = ~rv; bcnt[d]++; end
                end
                lat  = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(1, 3));
                spur = ($urandom_range(0, 3) == 0);
                if (spur) begin
                    if (t.is_wr) wdone[d] = 1'b1;
                    else begin dval[d] = 1'b1; din[d] = ~rv; end
                end
                @(posedge clk); #1;
                wdone[d] = 1'b0; dval[d] = 1'b0;
                if (!drop) begin
                    if (lat > 1) begin repeat (lat - 1) @(posedge clk); #1; end
                    if (t.is_wr) begin
                        wdone[d] = 1'b1;
                        if (spur) begin dval[d] = 1'b1; din[d] = 8'hA5; end
                    end else begin
                        dval[d] = 1'b1; din[d] = rv;
                        if (spur) wdone[d] = 1'b1;
                    end
                    @(posedge clk); #1;
                    wdone[d] = 1'b0; dval[d] = 1'b0;
                end
            end
        end
    endtask

    // Expected transaction list and outcome derived from the sequencing rules alone.
    task automatic build_model(input bit verify, output int ecode, output int eix);
        tx_t t;
        int bad;
        bit to;
        exp_q.delete();
        ecode = 0; eix = 0;
        for (int a = 0; a <= MAXR; a++) begin
            t.is_wr = 1'b0; t.a = PADDR; t.dat = 8'h00; t.cyc = 0; t.gap18 = 1'b0;
            exp_q.push_back(t);
            if (a >= pbad) break;
            if (a == MAXR) begin ecode = 1; return; end
        end
        for (int e = 0; e < NE; e++) begin
            bad = 0;
            if (e == fe && kind == 2) bad = nbad;
            if (e == fe && kind == 1 && verify) bad = nbad;
            to = 1'b0;
            for (int a = 0; a <= MAXR; a++) begin
                t.is_wr = 1'b1; t.a = taddr_a[e]; t.dat = tdata_a[e]; t.gap18 = to;
                exp_q.push_back(t);
                to = (a < bad) && (kind == 2);
                if (verify && !to) begin
                    t.is_wr = 1'b0; t.gap18 = 1'b0;
                    exp_q.push_back(t);
                end
                if (a >= bad) break;
                if (a == MAXR) begin ecode = (kind == 2) ? 2 : 3; eix = e; return; end
            end
        end
    endtask

    task automatic compare_run(input int d);
        tx_t got[$];
        int ecode, eix, n;
        string p;
        p = (d == 0) ? "A" : "B";
        build_model(d == 0, ecode, eix);
        if (d == 0) got = mlog0; else got = mlog1;
        check({p, " ntx"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s tx%0d kind", p, i), got[i].is_wr, exp_q[i].is_wr);
            check($sformatf("%s tx%0d addr", p, i), got[i].a, exp_q[i].a);
            if (exp_q[i].is_wr) check($sformatf("%s tx%0d data", p, i), got[i].dat, exp_q[i].dat);
            if (exp_q[i].gap18 && i > 0) check($sformatf("%s tx%0d retry gap", p, i), got[i].cyc - got[i-1].cyc, 18);
        end
        check({p, " busy"}, busy[d], 1'b0);
        check({p, " init_done"}, done[d], ecode == 0);
        check({p, " init_error"}, err[d], ecode != 0);
        check({p, " error_code"}, code[d], ecode);
        check({p, " error_index"}, eidx[d], eix);
        if (ecode == 0) begin
            check({p, " done addr"}, addr[d], 0);
            check({p, " done data"}, dout[d], 0);
        end
    endtask

    task automatic clear_run();
        mlog0.delete(); mlog1.delete();
        for (int d = 0; d < 2; d++) begin pcnt[d] = 0; bcnt[d] = 0; end
    endtask

    task automatic set_scn(input int p, input int f, input int k, input int nb);
        pbad = p; fe = f; kind = k; nbad = nb;
    endtask

    task automatic pulse_restart();
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy != 2'b00 && n < 3000);
        check("sequence finished", busy, 2'b00);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d busy", tag, d), busy[d], 1'b1);
            check($sformatf("%s d%0d strobes", tag, d), {rd[d], wr[d]}, 2'b00);
            check($sformatf("%s d%0d addr/data", tag, d), {addr[d], dout[d]}, 0);
            check($sformatf("%s d%0d flags", tag, d), {done[d], err[d], code[d], eidx[d]}, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1; restart = 1'b0; dval = '0; wdone = '0; din = '0;
        fork responder(0); responder(1); join_none

        set_scn(0, 0, 0, 0);
        clear_run();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rd cycle0", rd[0], 1'b0);
        @(negedge clk);
        check("rd cycle1", rd[0], 1'b1);
        wait_idle();
        compare_run(0); compare_run(1);

        for (run = 1; run < 12; run++) begin
            case (run)
                1: set_scn(3, 0, 0, 0);
                2: set_scn(0, 2, 2, 3);
                3: set_scn(0, 1, 1, 1);
                default: begin
                    pbad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    kind = $urandom_range(0, 2);
                    nbad = $urandom_range(1, 3);
                    fe   = (pbad > 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                end
            endcase
            clear_run();
            pulse_restart();
            wait_idle();
            compare_run(0); compare_run(1);
        end

        // Reset inside entry 3's write wait, with restart held alongside it.
        set_scn(0, 0, 0, 0);
        clear_run();
        pulse_restart();
        found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            @(negedge clk);
            if (wr[0] && addr[0] == 9'h009) found = 1'b1;
        end
        check("reached entry 3 write", found, 1'b1);
        @(posedge clk); #1 reset = 1'b1; restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid reset");
        repeat (20) @(posedge clk);
        #1 clear_run(); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        wait_idle();
        compare_run(0); compare_run(1);

        clear_run();
        pulse_restart();
        wait_idle();
        compare_run(0); compare_run(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
